// File: rtl/write_back_arbiter.sv
// Round-robin write-back arbiter: FUs share one registered write-back port.
// Optional contention counter enabled by DRAGONFANG_WB_CONTENTION_COUNTER_EN.
module write_back_arbiter #(
  parameter int NUMBER_FUNCTIONAL_UNITS = 21,
  parameter int NUMBER_REQUESTERS       = NUMBER_FUNCTIONAL_UNITS,
  parameter int COUNTER_WIDTH           = 32,
  parameter int TAG_WIDTH               = 6,
  parameter int DATA_WIDTH              = 32,
  localparam int PACKET_WIDTH           = TAG_WIDTH + DATA_WIDTH
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic [NUMBER_REQUESTERS-1:0]              request_valid,
  input  logic [NUMBER_REQUESTERS*PACKET_WIDTH-1:0] request_packet,
  output logic [NUMBER_REQUESTERS-1:0]              request_ready,
  output logic                                      write_back_valid,
  output logic [PACKET_WIDTH-1:0]                   write_back_packet,
  input  logic                                      write_back_ready
`ifdef DRAGONFANG_WB_CONTENTION_COUNTER_EN
  ,
  output logic [COUNTER_WIDTH-1:0]                  contention_count
`endif
);

  localparam int PTR_W = (NUMBER_REQUESTERS > 1) ? $clog2(NUMBER_REQUESTERS) : 1;
  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUMBER_REQUESTERS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUMBER_REQUESTERS - 1);
  localparam logic [NUMBER_REQUESTERS-1:0] ONE = NUMBER_REQUESTERS'(1);

  logic [PTR_W-1:0]             last_grant;
  logic [PTR_W-1:0]             grant_idx;
  logic                         grant_any;
  logic                         accept;
  logic                         grant;
  logic [NUMBER_REQUESTERS-1:0] grant_onehot;
  logic [PACKET_WIDTH-1:0]      sel_packet;

  assign accept = ~write_back_valid | write_back_ready;
  assign grant  = grant_any & accept & reset_n;

  // Search starts one past the last winner and wraps; first valid requester wins.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 1; i <= NUMBER_REQUESTERS; i++) begin
      sum = {1'b0, last_grant} + (PTR_W+1)'(i);
      if (sum >= N_EXT) sum = sum - N_EXT;
      cand = sum[PTR_W-1:0];
      if (!grant_any && request_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_onehot  = ONE << grant_idx;
  assign request_ready = grant ? grant_onehot : '0;

  // AND-OR select of the granted packet; only feeds the output register.
  always_comb begin
    sel_packet = '0;
    for (int i = 0; i < NUMBER_REQUESTERS; i++) begin
      if (grant_onehot[i]) sel_packet = sel_packet | request_packet[i*PACKET_WIDTH +: PACKET_WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_back_valid  <= 1'b0;
      write_back_packet <= '0;
      last_grant        <= LAST_IDX;
    end else if (accept) begin
      write_back_valid <= grant_any;
      if (grant_any) begin
        write_back_packet <= sel_packet;
        last_grant        <= grant_idx;
      end
    end
  end

`ifdef DRAGONFANG_WB_CONTENTION_COUNTER_EN
  logic multi_valid;

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign multi_valid = |(request_valid & (request_valid - ONE));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contention_count <= '0;
    end else if (multi_valid && (contention_count != '1)) begin
      contention_count <= contention_count + COUNTER_WIDTH'(1);
    end
  end
`endif

endmodule

// File: doc/write_back_arbiter.md
WRITE_BACK_ARBITER -- requirements
Module: write_back_arbiter

Interface
REQ-001 SHALL have parameter NUMBER_REQUESTERS, default NUMBER_FUNCTIONAL_UNITS (21), the number of functional units sharing the write-back port.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 32, the width of the contention counter.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have port request_valid, input, NUMBER_REQUESTERS bits, a per-FU result-ready flag.
REQ-006 SHALL have port request_packet, input, NUMBER_REQUESTERS x data_packet_t, the per-FU tag+data result.
REQ-007 SHALL have port request_ready, output, NUMBER_REQUESTERS bits, a one-hot grant; the FU result is consumed this cycle.
REQ-008 SHALL have port write_back_valid, output, 1 bit, indicating that the output register holds a result.
REQ-009 SHALL have port write_back_packet, output, data_packet_t, the result to the register file and tag broadcast.
REQ-010 SHALL have port write_back_ready, input, 1 bit, indicating that the register file accepts write_back_packet this cycle.
REQ-011 SHALL have port contention_count, output, COUNTER_WIDTH bits, present only with DRAGONFANG_WB_CONTENTION_COUNTER_EN.

Function
REQ-012 SHALL contain one output register stage (valid + data_packet_t); the stage is empty when write_back_valid=0.
REQ-013 SHALL define accept = ~write_back_valid | write_back_ready; grants SHALL occur only in cycles where accept=1.
REQ-014 SHALL assert at most one request_ready bit per cycle, and only for a requester with request_valid=1.
REQ-015 SHALL use round-robin arbitration: the search starts at last_grant+1, wraps from NUMBER_REQUESTERS-1 to 0, and the first valid requester wins.
REQ-016 SHALL update last_grant only on a grant; a cycle with no grant leaves it unchanged.
REQ-017 SHALL set latency to 1 cycle: a grant in cycle t SHALL produce write_back_valid=1 with that packet in cycle t+1.
REQ-018 SHALL sustain full throughput: with write_back_ready=1 continuously, one grant per cycle back-to-back.
REQ-019 SHALL hold write_back_packet and write_back_valid stable while write_back_valid=1 and write_back_ready=0, and SHALL issue no grants in that state.
REQ-020 SHALL, when write_back_ready=1 and there is no valid request, clear write_back_valid next cycle.
REQ-021 SHALL, on simultaneous drain and grant in the same cycle, load the new packet and keep write_back_valid=1.
REQ-022 SHALL, when a single requester is valid, grant it regardless of pointer position.
REQ-023 SHALL require that a requester holds request_packet stable until granted; the arbiter registers the packet only on a grant.
REQ-024 SHALL make request_ready combinational from request_valid, last_grant and accept, with no combinational path from request_packet.

Reset
REQ-025 SHALL, on reset_n=0, asynchronously force write_back_valid=0, write_back_packet='0 and last_grant=NUMBER_REQUESTERS-1, so that FU0 has first priority.
REQ-026 SHALL drive request_ready=0 while reset_n=0.
REQ-027 SHALL discard any packet held in the output stage when reset occurs mid-stall; it is never presented after reset.
REQ-028 SHALL reset contention_count to 0 when present.

Configuration
REQ-029 SHALL, with DRAGONFANG_WB_CONTENTION_COUNTER_EN defined, increment contention_count by 1 every cycle in which two or more request_valid bits are set.
REQ-030 SHALL saturate contention_count at all-ones and never wrap.
REQ-031 SHALL, without DRAGONFANG_WB_CONTENTION_COUNTER_EN, omit the port and counter logic; arbitration behaviour is identical in both builds.

Verification
REQ-032 SHALL cover reset priority: after reset, request_valid=0x000003 with write_back_ready=1 -> grant FU0 in cycle 0, FU1 in cycle 1; write_back_packet.tag matches each FU's tag one cycle after its grant.
REQ-033 SHALL cover wrap-around: last_grant=20, request_valid bits 20 and 2 set -> grant FU2, then FU20.
REQ-034 SHALL cover stall: write_back_valid=1 with tag=5 and write_back_ready=0 for 3 cycles while FU7 is valid -> packet unchanged, request_ready=0 for all 3 cycles; FU7 is granted in the cycle write_back_ready=1.
REQ-035 SHALL cover full throughput: all 21 FUs valid with write_back_ready=1 for 21 cycles -> each FU granted exactly once, in order 0..20, with write_back_valid=1 from cycle 1 onward.
REQ-036 SHALL cover reset mid-stall: reset_n pulsed low while write_back_valid=1 -> write_back_valid=0 immediately, and the next grant goes to the lowest-index valid FU.
REQ-037 SHALL cover the counter (EN build): 3 FUs valid for 10 cycles -> contention_count=10; with the counter preset near all-ones it holds at all-ones.
